alu_dispatch: RTL and testbench

//  Issue side of the ALU-unit interface (unit_en / op_a / op_b -> result). Holds a small

---
 rtl/alu_dispatch_pkg.sv | 21 ++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_dispatch.sv | 124 ++++++++++++
 tb/tb_alu_dispatch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_dispatch_pkg.sv
// Shared opcode constants, FSM state encoding and the opcode-to-enable decode for the ALU dispatch block.
package alu_dispatch_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_READ = 2'b01,
      ST_EXEC = 2'b10,
      ST_WB   = 2'b11
   } state_t;

   // Unit enable bit index equals the opcode value.
   function automatic logic [3:0] op_onehot(input logic [1:0] op);
      return 4'b0001 << op;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port, three asynchronous read ports (rs1, rs2, debug).
module alu_regfile #(
   parameter int DATA_W = 4,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NREG = 2 ** REG_AW;

   logic [DATA_W-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// Issue side of the ALU unit interface: read operands, pulse one unit enable for one cycle, write the result back.
// Accept at t, unit_en at t+2, writeback/done at t+3, ready again at t+4.
module alu_dispatch
   import alu_dispatch_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_op,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic [REG_AW-1:0] instr_rs1,
   input  logic [REG_AW-1:0] instr_rs2,
   input  logic              ld_valid,
   input  logic [REG_AW-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [3:0]        unit_en,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic              done,
   input  logic [REG_AW-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            state, state_nxt;
   logic [1:0]        op_q;
   logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
   logic [DATA_W-1:0] res_q;
   logic [3:0]        unit_en_nxt;
   logic              accept;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rs1_data, rs2_data;

   alu_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .rs1_addr (rs1_q),
      .rs2_addr (rs2_q),
      .dbg_addr (dbg_sel),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .dbg_data (dbg_data)
   );

   // Load and writeback share the single write port; they live in disjoint states.
   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      accept      = 1'b0;
      unit_en_nxt = 4'b0000;
      done        = 1'b0;
      rf_we       = 1'b0;
      rf_waddr    = rd_q;
      rf_wdata    = res_q;
      case (state)
         ST_IDLE: begin
            if (ld_valid) begin
               rf_we    = 1'b1;
               rf_waddr = ld_addr;
               rf_wdata = ld_data;
            end else begin
               instr_ready = 1'b1;
               if (instr_valid) begin
                  accept    = 1'b1;
                  state_nxt = ST_READ;
               end
            end
         end
         ST_READ: begin
            unit_en_nxt = op_onehot(op_q);
            state_nxt   = ST_EXEC;
         end
         ST_EXEC: begin
            state_nxt = ST_WB;
         end
         ST_WB: begin
            rf_we     = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         unit_en <= 4'b0000;
         op_a    <= '0;
         op_b    <= '0;
         op_q    <= 2'b00;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         res_q   <= '0;
      end else begin
         state   <= state_nxt;
         unit_en <= unit_en_nxt;
         if (accept) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
         end
         if (state == ST_READ) begin
            op_a <= rs1_data;
            op_b <= rs2_data;
         end
         if (state == ST_EXEC) begin
            res_q <= alu_result;
         end
      end
   end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with behavioural AND/OR/XOR/ADD units OR-combined into alu_result.
module tb_alu_dispatch;
   import alu_dispatch_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [1:0] instr_op;
   logic [1:0] instr_rd, instr_rs1, instr_rs2;
   logic       ld_valid;
   logic [1:0] ld_addr;
   logic [3:0] ld_data;
   logic [3:0] unit_en;
   logic [3:0] op_a, op_b;
   logic [3:0] alu_result;
   logic       done;
   logic [1:0] dbg_sel;
   logic [3:0] dbg_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_dispatch #(.DATA_W(4), .REG_AW(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_rs1   (instr_rs1),
      .instr_rs2   (instr_rs2),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .unit_en     (unit_en),
      .op_a        (op_a),
      .op_b        (op_b),
      .alu_result  (alu_result),
      .done        (done),
      .dbg_sel     (dbg_sel),
      .dbg_data    (dbg_data)
   );

   // Units drive zero unless enabled; ADD wraps at 4 bits.
   logic [3:0] and_res, or_res, xor_res, add_res;
   assign and_res    = unit_en[0] ? (op_a & op_b) : 4'h0;
   assign or_res     = unit_en[1] ? (op_a | op_b) : 4'h0;
   assign xor_res    = unit_en[2] ? (op_a ^ op_b) : 4'h0;
   assign add_res    = unit_en[3] ? (op_a + op_b) : 4'h0;
   assign alu_result = and_res | or_res | xor_res | add_res;

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         assert ($onehot0(unit_en)) else begin
            failures++;
            $error("FAIL onehot observed=%b expected=at_most_one_bit", unit_en);
         end
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [1:0] r, input logic [3:0] exp, input string tag);
      dbg_sel = r;
      #1;
      chk(tag, {4'h0, dbg_data}, {4'h0, exp});
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load(input logic [1:0] a, input logic [3:0] d);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      tick();
      ld_valid = 1'b0;
   endtask

   // Full single-instruction flow with per-cycle timing checks; optional ld_valid noise to R0.
   task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] ea, input logic [3:0] eb,
                        input logic [3:0] pre, input logic [3:0] er, input bit noise);
      instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
      instr_valid = 1'b1;
      #1;
      chk("ready_idle", {7'h0, instr_ready}, 8'h01);
      tick();
      instr_valid = 1'b0;
      if (noise) begin
         ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 4'hF;
      end
      #1;
      chk("ready_read", {7'h0, instr_ready}, 8'h00);
      chk("en_read", {4'h0, unit_en}, 8'h00);
      tick();
      chk("en_exec", {4'h0, unit_en}, {4'h0, 4'b0001 << op});
      chk("op_a", {4'h0, op_a}, {4'h0, ea});
      chk("op_b", {4'h0, op_b}, {4'h0, eb});
      tick();
      chk("done_wb", {7'h0, done}, 8'h01);
      chk("en_wb", {4'h0, unit_en}, 8'h00);
      peek(rd, pre, "dbg_pre");
      tick();
      ld_valid = 1'b0;
      #1;
      chk("done_idle", {7'h0, done}, 8'h00);
      chk("ready_back", {7'h0, instr_ready}, 8'h01);
      peek(rd, er, "dbg_post");
   endtask

   initial begin
      instr_valid = 0; instr_op = 0; instr_rd = 0; instr_rs1 = 0; instr_rs2 = 0;
      ld_valid = 0; ld_addr = 0; ld_data = 0; dbg_sel = 0;
      reset_dut();
      #1;
      chk("rst_ready", {7'h0, instr_ready}, 8'h01);
      chk("rst_en", {4'h0, unit_en}, 8'h00);
      chk("rst_op_a", {4'h0, op_a}, 8'h00);
      chk("rst_op_b", {4'h0, op_b}, 8'h00);
      chk("rst_done", {7'h0, done}, 8'h00);
      for (int r = 0; r < 4; r++) peek(2'(r), 4'h0, "rst_reg");

      // 1: XOR R3,R1,R2 with R1=A, R2=6
      load(2'd1, 4'hA);
      load(2'd2, 4'h6);
      issue(OP_XOR, 2'd3, 2'd1, 2'd2, 4'hA, 4'h6, 4'h0, 4'hC, 1'b0);

      // 2: ADD R0,R1,R1 wraps to 4
      issue(OP_ADD, 2'd0, 2'd1, 2'd1, 4'hA, 4'hA, 4'h0, 4'h4, 1'b0);
      peek(2'd1, 4'hA, "t2_r1");
      peek(2'd2, 4'h6, "t2_r2");
      peek(2'd3, 4'hC, "t2_r3");

      // 3: load wins over instruction in the same cycle
      instr_op = OP_AND; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
      instr_valid = 1'b1;
      ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 4'h3;
      #1;
      chk("t3_ready_ld", {7'h0, instr_ready}, 8'h00);
      tick();
      ld_valid = 1'b0;
      peek(2'd1, 4'h3, "t3_loaded");
      issue(OP_AND, 2'd3, 2'd1, 2'd2, 4'h3, 4'h6, 4'hC, 4'h2, 1'b0);

      // 4: back-to-back with the second instruction held valid
      load(2'd1, 4'hA);
      instr_op = OP_AND; instr_rd = 2'd2; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
      instr_valid = 1'b1;
      #1;
      chk("t4_ready0", {7'h0, instr_ready}, 8'h01);
      tick();
      instr_op = OP_OR; instr_rd = 2'd1; instr_rs1 = 2'd2; instr_rs2 = 2'd2;
      #1;
      chk("t4_ready_read", {7'h0, instr_ready}, 8'h00);
      tick();
      chk("t4_en_and", {4'h0, unit_en}, 8'h01);
      chk("t4_ready_exec", {7'h0, instr_ready}, 8'h00);
      tick();
      chk("t4_done1", {7'h0, done}, 8'h01);
      chk("t4_ready_wb", {7'h0, instr_ready}, 8'h00);
      tick();
      chk("t4_ready_t4", {7'h0, instr_ready}, 8'h01);
      peek(2'd2, 4'h2, "t4_r2");
      tick();
      instr_valid = 1'b0;
      tick();
      chk("t4_en_or", {4'h0, unit_en}, 8'h02);
      chk("t4_op_a", {4'h0, op_a}, 8'h02);
      chk("t4_op_b", {4'h0, op_b}, 8'h02);
      tick();
      chk("t4_done2", {7'h0, done}, 8'h01);
      tick();
      peek(2'd1, 4'h2, "t4_r1");

      // 5: reset during EXEC aborts the instruction
      reset_dut();
      load(2'd1, 4'hA);
      load(2'd2, 4'h6);
      instr_op = OP_XOR; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("t5_en_exec", {4'h0, unit_en}, 8'h04);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_en_rst", {4'h0, unit_en}, 8'h00);
      chk("t5_done_rst", {7'h0, done}, 8'h00);
      chk("t5_ready", {7'h0, instr_ready}, 8'h01);
      peek(2'd3, 4'h0, "t5_r3_a");
      tick();
      chk("t5_done_after", {7'h0, done}, 8'h00);
      peek(2'd3, 4'h0, "t5_r3_b");

      // 6: loads outside IDLE are dropped
      load(2'd1, 4'hA);
      load(2'd2, 4'h6);
      issue(OP_XOR, 2'd3, 2'd1, 2'd2, 4'hA, 4'h6, 4'h0, 4'hC, 1'b1);
      peek(2'd0, 4'h0, "t6_r0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
